axi_lite_pwm_led: RTL



---
 rtl/axi_lite_pwm_led.sv | 272 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/axi_lite_pwm_led.sv
// AXI4-Lite register block driving a two-channel PWM on the green/red PL LEDs.
// Period and duty writes land in shadow registers and are adopted only at a period wrap.
module axi_lite_pwm_led #(
    parameter int          ADDR_W         = 8,
    parameter logic [31:0] DEFAULT_PERIOD = 32'd99999,
    parameter logic [31:0] ID_VALUE       = 32'h5057_4D01
) (
    input  logic              FCLK_CLK0,
    input  logic              FCLK_CLK0_RST,
    input  logic [ADDR_W-1:0] s_axi_awaddr,
    input  logic [2:0]        s_axi_awprot,
    input  logic              s_axi_awvalid,
    output logic              s_axi_awready,
    input  logic [31:0]       s_axi_wdata,
    input  logic [3:0]        s_axi_wstrb,
    input  logic              s_axi_wvalid,
    output logic              s_axi_wready,
    output logic [1:0]        s_axi_bresp,
    output logic              s_axi_bvalid,
    input  logic              s_axi_bready,
    input  logic [ADDR_W-1:0] s_axi_araddr,
    input  logic [2:0]        s_axi_arprot,
    input  logic              s_axi_arvalid,
    output logic              s_axi_arready,
    output logic [31:0]       s_axi_rdata,
    output logic [1:0]        s_axi_rresp,
    output logic              s_axi_rvalid,
    input  logic              s_axi_rready,
    output logic              led_g,
    output logic              led_r,
    output logic              period_tick
);

    localparam int IDX_W = ADDR_W - 2;

    localparam logic [IDX_W-1:0] IDX_CTRL   = IDX_W'(0);
    localparam logic [IDX_W-1:0] IDX_PERIOD = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_DUTY_G = IDX_W'(2);
    localparam logic [IDX_W-1:0] IDX_DUTY_R = IDX_W'(3);
    localparam logic [IDX_W-1:0] IDX_COUNT  = IDX_W'(4);
    localparam logic [IDX_W-1:0] IDX_ID     = IDX_W'(5);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // write channel
    logic             awready_q, awready_d;
    logic             wready_q, wready_d;
    logic             aw_full_q, aw_full_d;
    logic             w_full_q, w_full_d;
    logic [IDX_W-1:0] aw_idx_q, aw_idx_d;
    logic [31:0]      w_data_q, w_data_d;
    logic [3:0]       w_strb_q, w_strb_d;
    logic             bvalid_q, bvalid_d;
    logic [1:0]       bresp_q, bresp_d;

    // read channel
    logic             arready_q, arready_d;
    logic             rvalid_q, rvalid_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [1:0]       rresp_q, rresp_d;

    // register file: shadows written by the bus, actives used by the PWM
    logic [1:0]       ctrl_q, ctrl_d;
    logic [31:0]      per_sh_q, per_sh_d;
    logic [31:0]      dg_sh_q, dg_sh_d;
    logic [31:0]      dr_sh_q, dr_sh_d;
    logic [31:0]      per_q, per_d;
    logic [31:0]      dg_q, dg_d;
    logic [31:0]      dr_q, dr_d;
    logic [31:0]      cnt_q, cnt_d;
    logic             led_g_q, led_g_d;
    logic             led_r_q, led_r_d;

    logic             aw_hs, w_hs, ar_hs, wr_exec, wrap;
    logic             wr_ok, rd_ok;
    logic [31:0]      wr_old, wr_new, rd_data;
    logic [IDX_W-1:0] ar_idx;

    logic             unused_ok;
    assign unused_ok = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    assign aw_hs   = s_axi_awvalid && awready_q;
    assign w_hs    = s_axi_wvalid && wready_q;
    assign ar_hs   = s_axi_arvalid && arready_q;
    assign wr_exec = aw_full_q && w_full_q;
    assign ar_idx  = s_axi_araddr[ADDR_W-1:2];
    assign wrap    = ctrl_q[0] && (cnt_q == per_q);

    // byte-lane merge of the held write into the addressed shadow
    always_comb begin
        wr_ok  = 1'b1;
        wr_old = 32'h0;
        case (aw_idx_q)
            IDX_CTRL:   wr_old = {30'h0, ctrl_q};
            IDX_PERIOD: wr_old = per_sh_q;
            IDX_DUTY_G: wr_old = dg_sh_q;
            IDX_DUTY_R: wr_old = dr_sh_q;
            default:    wr_ok  = 1'b0;
        endcase
        wr_new = wr_old;
        for (int i = 0; i < 4; i++) begin
            if (w_strb_q[i]) begin
                wr_new[i*8 +: 8] = w_data_q[i*8 +: 8];
            end
        end
    end

    always_comb begin
        rd_ok   = 1'b1;
        rd_data = 32'h0;
        case (ar_idx)
            IDX_CTRL:   rd_data = {30'h0, ctrl_q};
            IDX_PERIOD: rd_data = per_sh_q;
            IDX_DUTY_G: rd_data = dg_sh_q;
            IDX_DUTY_R: rd_data = dr_sh_q;
            IDX_COUNT:  rd_data = cnt_q;
            IDX_ID:     rd_data = ID_VALUE;
            default:    rd_ok   = 1'b0;
        endcase
    end

    always_comb begin
        aw_full_d = aw_full_q;
        aw_idx_d  = aw_idx_q;
        w_full_d  = w_full_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        ctrl_d    = ctrl_q;
        per_sh_d  = per_sh_q;
        dg_sh_d   = dg_sh_q;
        dr_sh_d   = dr_sh_q;

        if (aw_hs) begin
            aw_full_d = 1'b1;
            aw_idx_d  = s_axi_awaddr[ADDR_W-1:2];
        end
        if (w_hs) begin
            w_full_d = 1'b1;
            w_data_d = s_axi_wdata;
            w_strb_d = s_axi_wstrb;
        end

        if (wr_exec) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = wr_ok ? RESP_OKAY : RESP_SLVERR;
            case (aw_idx_q)
                IDX_CTRL:   ctrl_d   = wr_new[1:0];
                IDX_PERIOD: per_sh_d = wr_new;
                IDX_DUTY_G: dg_sh_d  = wr_new;
                IDX_DUTY_R: dr_sh_d  = wr_new;
                default:    ;
            endcase
        end else if (bvalid_q && s_axi_bready) begin
            bvalid_d = 1'b0;
        end

        // readies are registered, so they look at the next-cycle occupancy
        awready_d = !aw_full_d && !bvalid_d;
        wready_d  = !w_full_d && !bvalid_d;
    end

    always_comb begin
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_data;
            rresp_d  = rd_ok ? RESP_OKAY : RESP_SLVERR;
        end else if (rvalid_q && s_axi_rready) begin
            rvalid_d = 1'b0;
        end
        arready_d = !rvalid_d;
    end

    // PWM: wrap reloads actives from the pre-write shadows, so a same-cycle write waits a period
    always_comb begin
        cnt_d   = cnt_q;
        per_d   = per_q;
        dg_d    = dg_q;
        dr_d    = dr_q;
        led_g_d = ctrl_q[1];
        led_r_d = ctrl_q[1];
        if (!ctrl_q[0]) begin
            cnt_d = 32'h0;
            per_d = per_sh_q;
            dg_d  = dg_sh_q;
            dr_d  = dr_sh_q;
        end else begin
            led_g_d = (cnt_q < dg_q) ^ ctrl_q[1];
            led_r_d = (cnt_q < dr_q) ^ ctrl_q[1];
            if (wrap) begin
                cnt_d = 32'h0;
                per_d = per_sh_q;
                dg_d  = dg_sh_q;
                dr_d  = dr_sh_q;
            end else begin
                cnt_d = cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge FCLK_CLK0 or posedge FCLK_CLK0_RST) begin
        if (FCLK_CLK0_RST) begin
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            aw_full_q <= 1'b0;
            w_full_q  <= 1'b0;
            aw_idx_q  <= '0;
            w_data_q  <= 32'h0;
            w_strb_q  <= 4'h0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= 32'h0;
            rresp_q   <= 2'b00;
            ctrl_q    <= 2'b00;
            per_sh_q  <= DEFAULT_PERIOD;
            dg_sh_q   <= 32'h0;
            dr_sh_q   <= 32'h0;
            per_q     <= DEFAULT_PERIOD;
            dg_q      <= 32'h0;
            dr_q      <= 32'h0;
            cnt_q     <= 32'h0;
            led_g_q   <= 1'b0;
            led_r_q   <= 1'b0;
        end else begin
            awready_q <= awready_d;
            wready_q  <= wready_d;
            aw_full_q <= aw_full_d;
            w_full_q  <= w_full_d;
            aw_idx_q  <= aw_idx_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            ctrl_q    <= ctrl_d;
            per_sh_q  <= per_sh_d;
            dg_sh_q   <= dg_sh_d;
            dr_sh_q   <= dr_sh_d;
            per_q     <= per_d;
            dg_q      <= dg_d;
            dr_q      <= dr_d;
            cnt_q     <= cnt_d;
            led_g_q   <= led_g_d;
            led_r_q   <= led_r_d;
        end
    end

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;
    assign led_g         = led_g_q;
    assign led_r         = led_r_q;
    assign period_tick   = wrap;

endmodule
